// File: rtl/cosim_cycle_reporter.sv
`default_nettype none
// ============================================================================
// Module   : cosim_cycle_reporter
// Brief    : Pushes timestamped design "mark" events, overflow notices and
//            optional periodic heartbeats to the host over a 128-bit
//            valid/ready channel, buffered in a small record FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cosim_cycle_reporter #(
  parameter int TAG_BITS         = 16,
  parameter int FIFO_DEPTH       = 4,
  parameter int HEARTBEAT_PERIOD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mark_valid,
  input  logic [TAG_BITS-1:0] mark_tag,
  output logic                mark_accepted,
  output logic [31:0]         drop_count,
  output logic                to_host_valid,
  input  logic                to_host_ready,
  output logic [127:0]        to_host_data
);

  localparam int         c_ADDR_W    = $clog2(FIFO_DEPTH);
  localparam int         c_CNT_W     = c_ADDR_W + 1;
  localparam logic [7:0] c_KIND_MARK = 8'h01;
  localparam logic [7:0] c_KIND_HB   = 8'h02;
  localparam logic [7:0] c_KIND_OVF  = 8'h03;

  logic [63:0]         r_cycle;
  logic [15:0]         r_seq;
  logic [127:0]        r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_mark_acc;
  logic [31:0]         r_drop;
  logic                r_ovf_pend;
  logic                r_hb_pend;
  logic [63:0]         r_hb_ts;

  logic                w_full;
  logic                w_pop;
  logic                w_space;
  logic                w_push_mark;
  logic                w_push_ovf;
  logic                w_push_hb;
  logic                w_push;
  logic                w_drop;
  logic                w_hb_fire;
  logic [127:0]        w_rec;

  assign to_host_valid = (r_count != '0);
  assign to_host_data  = r_mem[r_rd_ptr];
  assign mark_accepted = r_mark_acc;
  assign drop_count    = r_drop;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_pop   = to_host_valid && to_host_ready;
  assign w_space = !w_full || w_pop;

  // One enqueue per cycle: mark beats overflow beats heartbeat.
  assign w_push_mark = mark_valid && w_space;
  assign w_drop      = mark_valid && !w_space;
  assign w_push_ovf  = !mark_valid && r_ovf_pend && w_space;
  assign w_push_hb   = !mark_valid && !r_ovf_pend && r_hb_pend && w_space;
  assign w_push      = w_push_mark || w_push_ovf || w_push_hb;

  // Assemble the record selected for enqueue this cycle.
  always_comb begin
    w_rec = {r_cycle, r_seq, c_KIND_MARK, 8'h00, 32'(mark_tag)};
    if (w_push_ovf) begin
      w_rec = {r_cycle, r_seq, c_KIND_OVF, 8'h00, r_drop};
    end else if (w_push_hb) begin
      w_rec = {r_hb_ts, r_seq, c_KIND_HB, 8'h00, 32'h0000_0000};
    end
  end

  // Heartbeat timer counts 0..PERIOD-1 and fires on the terminal count.
  generate
    if (HEARTBEAT_PERIOD > 0) begin : g_hb_on
      localparam int c_HB_W = (HEARTBEAT_PERIOD > 1) ? $clog2(HEARTBEAT_PERIOD) : 1;
      logic [c_HB_W-1:0] r_hb_timer;

      assign w_hb_fire = (r_hb_timer == c_HB_W'(HEARTBEAT_PERIOD - 1));

      // Free-running timer, reloaded to zero on each fire.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_hb_timer <= '0;
        end else if (w_hb_fire) begin
          r_hb_timer <= '0;
        end else begin
          r_hb_timer <= r_hb_timer + 1'b1;
        end
      end
    end else begin : g_hb_off
      assign w_hb_fire = 1'b0;
    end
  endgenerate

  // Free-running timestamp and the sequence number of enqueued records.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cycle <= '0;
      r_seq   <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_push) begin
        r_seq <= r_seq + 16'd1;
      end
    end
  end

  // Record storage; contents only matter while the slot is occupied.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= w_rec;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop accounting; repeated drops coalesce into one pending overflow record.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop     <= '0;
      r_ovf_pend <= 1'b0;
      r_mark_acc <= 1'b0;
    end else begin
      r_mark_acc <= w_push_mark;
      if (w_drop) begin
        r_ovf_pend <= 1'b1;
        if (r_drop != 32'hFFFF_FFFF) begin
          r_drop <= r_drop + 32'd1;
        end
      end else if (w_push_ovf) begin
        r_ovf_pend <= 1'b0;
      end
    end
  end

  // Pending heartbeat; a new fire overwrites the timestamp of an unsent one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hb_pend <= 1'b0;
      r_hb_ts   <= '0;
    end else if (w_hb_fire) begin
      r_hb_pend <= 1'b1;
      r_hb_ts   <= r_cycle;
    end else if (w_push_hb) begin
      r_hb_pend <= 1'b0;
    end
  end

endmodule
`default_nettype wire
